booth_factorial_engine: RTL and testbench



---
 rtl/booth_factorial_engine_if.sv | 28 ++
 rtl/booth_factorial_engine.sv | 136 +++++++++++++
 tb/tb_booth_factorial_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/booth_factorial_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_factorial_engine_if
// Purpose  : Start/busy/done handshake and result bus of the factorial engine.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_factorial_engine_if #(
  parameter int N_W = 8,
  parameter int P_W = 32
);
  logic           i_start;
  logic [N_W-1:0] i_n_in;
  logic           o_busy;
  logic           o_done;
  logic [P_W-1:0] o_product;
  logic           o_overflow;

  modport master (
    output i_start, i_n_in,
    input  o_busy, o_done, o_product, o_overflow
  );

  modport slave (
    input  i_start, i_n_in,
    output o_busy, o_done, o_product, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/booth_factorial_engine.sv
`default_nettype none
// ============================================================================
// Module   : booth_factorial_engine
// Purpose  : Iterative n! as a chain of radix-2 Booth multiplications.
// Revision : 1.0 - initial release
// ============================================================================
module booth_factorial_engine #(
  parameter int N_W = 8,
  parameter int P_W = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  booth_factorial_engine_if.slave   bus
);
  localparam int c_A_W   = P_W + 2;
  localparam int c_Q_W   = N_W + 1;
  localparam int c_F_W   = c_A_W + c_Q_W;
  localparam int c_CNT_W = $clog2(N_W + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STEP  = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [P_W-1:0]     r_acc;
  logic [N_W-1:0]     r_k;
  logic               r_ovf;
  logic [c_A_W-1:0]   r_a;
  logic [c_A_W-1:0]   r_m;
  logic [c_Q_W-1:0]   r_q;
  logic               r_q1;
  logic [c_CNT_W-1:0] r_cnt;
  logic [P_W-1:0]     r_product;
  logic               r_overflow;

  logic               w_n_small;
  logic               w_cnt_last;
  logic               w_k_last;
  logic [c_A_W-1:0]   w_sum;
  logic [c_F_W-1:0]   w_f;
  logic               w_ovf_nxt;

  assign w_n_small  = (bus.i_n_in < N_W'(2));
  assign w_cnt_last = (r_cnt == c_CNT_W'(1));
  assign w_k_last   = (r_k == N_W'(1));
  assign w_f        = {r_a, r_q};
  assign w_ovf_nxt  = r_ovf | (|w_f[c_F_W-1:P_W]);

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = w_n_small ? S_DONE : S_LOAD;
      S_LOAD:  w_state_nxt = S_STEP;
      S_STEP:  if (w_cnt_last) w_state_nxt = S_ACCUM;
      S_ACCUM: w_state_nxt = w_k_last ? S_DONE : S_LOAD;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The result registers load on the edge that enters DONE, so product and
  // overflow are already valid during the single done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_k        <= '0;
      r_ovf      <= 1'b0;
      r_a        <= '0;
      r_m        <= '0;
      r_q        <= '0;
      r_q1       <= 1'b0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_acc <= w_n_small ? P_W'(1) : P_W'(bus.i_n_in);
            r_k   <= bus.i_n_in - N_W'(1);
            r_ovf <= 1'b0;
            if (w_n_small) begin
              r_product  <= P_W'(1);
              r_overflow <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          r_a   <= '0;
          r_m   <= {2'b00, r_acc};
          r_q   <= {1'b0, r_k};
          r_q1  <= 1'b0;
          r_cnt <= c_CNT_W'(N_W + 1);
        end
        S_STEP: begin
          r_a   <= {w_sum[c_A_W-1], w_sum[c_A_W-1:1]};
          r_q   <= {w_sum[0], r_q[c_Q_W-1:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        S_ACCUM: begin
          r_acc <= w_f[P_W-1:0];
          r_ovf <= w_ovf_nxt;
          r_k   <= r_k - N_W'(1);
          if (w_k_last) begin
            r_product  <= w_f[P_W-1:0];
            r_overflow <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_done     = (r_state == S_DONE);
  assign bus.o_product  = r_product;
  assign bus.o_overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_booth_factorial_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_factorial_engine
// Purpose  : Scoreboard bench for booth_factorial_engine against a factorial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_factorial_engine;
  localparam int N_W = 8;
  localparam int P_W = 32;
  localparam int c_TMO = 20000;

  typedef struct {
    int             n;
    logic [P_W-1:0] p;
    logic           ov;
    longint         start_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     in_rst = 1'b1;
  exp_t   sb[$];
  logic [P_W-1:0] last_prod = '0;
  logic           last_ov = 1'b0;

  booth_factorial_engine_if #(.N_W(N_W), .P_W(P_W)) bif ();

  booth_factorial_engine #(.N_W(N_W), .P_W(P_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // n! mod 2^P_W with overflow meaning the exact n! reaches 2^P_W.
  function automatic void model(input int n, output logic [P_W-1:0] p, output logic ov);
    logic [127:0] exact;
    logic [127:0] modp;
    exact = 128'd1;
    modp  = 128'd1;
    ov    = 1'b0;
    for (int i = 2; i <= n; i++) begin
      modp = (modp * 128'(i)) % (128'd1 << P_W);
      if (!ov) begin
        exact = exact * 128'(i);
        if ((exact >> P_W) != 0) ov = 1'b1;
      end
    end
    p = modp[P_W-1:0];
  endfunction

  function automatic int exp_lat(input int n);
    return (n < 2) ? 0 : (n - 1) * (N_W + 3);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: compares every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (bif.o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("product_n%0d", e.n), longint'(bif.o_product), longint'(e.p));
        chk($sformatf("overflow_n%0d", e.n), longint'(bif.o_overflow), longint'(e.ov));
        chk($sformatf("latency_n%0d", e.n), cyc - e.start_cyc - 1, longint'(exp_lat(e.n)));
      end
    end else if (!in_rst) begin
      chk("result_hold", longint'({bif.o_overflow, bif.o_product}),
          longint'({last_ov, last_prod}));
    end
    last_prod = bif.o_product;
    last_ov   = bif.o_overflow;
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (bif.o_busy && t < c_TMO) begin
      @(negedge clk);
      t++;
    end
    if (bif.o_busy) chk("idle_timeout", 1, 0);
  endtask

  // Called at a negedge with the DUT idle; start is accepted at the next edge.
  task automatic issue(input int n);
    exp_t e;
    e.n = n;
    model(n, e.p, e.ov);
    e.start_cyc = cyc;
    sb.push_back(e);
    bif.i_start = 1'b1;
    bif.i_n_in  = N_W'(n);
  endtask

  // Full transaction with random ignored starts injected while busy.
  task automatic run(input int n);
    int bcnt;
    int t;
    wait_idle();
    issue(n);
    bcnt = 0;
    t = 0;
    @(negedge clk);
    while (bif.o_busy && t < c_TMO) begin
      bcnt++;
      bif.i_start = 1'(($urandom % 4) == 0);
      bif.i_n_in  = N_W'($urandom);
      @(negedge clk);
      t++;
    end
    bif.i_start = 1'b0;
    chk($sformatf("busy_cycles_n%0d", n), longint'(bcnt), longint'(exp_lat(n) + 1));
  endtask

  initial begin
    int t;
    bif.i_start = 1'b0;
    bif.i_n_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(bif.o_busy), 0);
    chk("rst_done", longint'(bif.o_done), 0);
    chk("rst_product", longint'(bif.o_product), 0);
    chk("rst_overflow", longint'(bif.o_overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;

    run(0);
    run(1);
    run(5);
    run(12);
    run(13);
    run(2);

    // start held high with n_in toggling: first value wins, next start takes 7
    wait_idle();
    issue(5);
    t = 0;
    do begin
      @(negedge clk);
      bif.i_n_in = (bif.i_n_in == N_W'(5)) ? N_W'(7) : N_W'(5);
      t++;
    end while (!bif.o_done && t < c_TMO);
    if (!bif.o_done) chk("held_start_timeout", 1, 0);
    @(negedge clk);
    issue(7);
    @(negedge clk);
    bif.i_start = 1'b0;

    // reset mid-operation aborts with no done pulse
    wait_idle();
    issue(10);
    @(negedge clk);
    bif.i_start = 1'b0;
    repeat (19) @(negedge clk);
    in_rst = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", longint'(bif.o_busy), 0);
    chk("abort_done", longint'(bif.o_done), 0);
    chk("abort_product", longint'(bif.o_product), 0);
    chk("abort_overflow", longint'(bif.o_overflow), 0);
    @(negedge clk);
    in_rst = 1'b0;
    run(3);

    for (int i = 0; i < 10; i++) run($urandom_range(0, 20));
    run($urandom_range(21, 40));
    run(34);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
